// File: rtl/mem_access_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto a single SPI-memory
// port. Load/store wins collisions; requests are validated at grant and results formatted at retire.
module mem_access_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic        ls_err,
    output logic [31:0] ls_rdata,
    output logic        mem_start,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_num_bytes,
    output logic        mem_is_write,
    output logic [31:0] mem_wdata,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RETIRE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    // Illegal size, misalignment, or an address outside the two mapped 16 MiB regions.
    function automatic logic req_illegal(input logic [31:0] addr, input logic [1:0] size);
        logic bad;
        bad = 1'b0;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr[0];
            2'd2:    bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad | ((addr[31:24] != 8'h00) && (addr[31:24] != 8'h01));
    endfunction

    // Memory returns data left-aligned; shift down and extend to 32 bits.
    function automatic logic [31:0] format_load(input logic [31:0] raw, input logic [1:0] size,
                                                input logic uns);
        logic [31:0] res;
        res = raw;
        case (size)
            2'd0:    res = uns ? {24'h000000, raw[31:24]} : {{24{raw[31]}}, raw[31:24]};
            2'd1:    res = uns ? {16'h0000, raw[31:16]} : {{16{raw[31]}}, raw[31:16]};
            default: res = raw;
        endcase
        return res;
    endfunction

    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        logic [2:0] nb;
        case (size)
            2'd0:    nb = 3'd1;
            2'd1:    nb = 3'd2;
            2'd2:    nb = 3'd4;
            default: nb = 3'd0;
        endcase
        return nb;
    endfunction

    state_t      state_r, state_nx_s;
    logic        port_ls_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [7:0]  timeout_r;
    logic        mem_start_r, mem_is_write_r;
    logic [31:0] mem_addr_r, mem_wdata_r;
    logic [2:0]  mem_num_bytes_r;
    logic        if_ack_r, if_err_r, ls_ack_r, ls_err_r;
    logic [31:0] if_rdata_r, ls_rdata_r;

    logic        req_any_s;
    logic [31:0] req_addr_s;
    logic [1:0]  req_size_s;
    logic        req_bad_s;
    logic        timeout_hit_s;

    // Request selection: load/store has priority; fetch is always a word read.
    always_comb begin
        req_any_s     = ls_req | if_req;
        req_addr_s    = ls_req ? ls_addr : if_addr;
        req_size_s    = ls_req ? ls_size : 2'd2;
        req_bad_s     = req_illegal(req_addr_s, req_size_s);
        timeout_hit_s = (timeout_r == TIMEOUT_LAST);
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_any_s) begin
                    state_nx_s = req_bad_s ? RETIRE : ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                if (mem_done || timeout_hit_s) begin
                    state_nx_s = RETIRE;
                end else begin
                    state_nx_s = ISSUE;
                end
            end
            RETIRE:  state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Grant latching, memory-side outputs, timeout and completion reporting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            port_ls_r       <= 1'b0;
            size_r          <= 2'd0;
            uns_r           <= 1'b0;
            timeout_r       <= 8'd0;
            mem_start_r     <= 1'b0;
            mem_is_write_r  <= 1'b0;
            mem_addr_r      <= 32'h0000_0000;
            mem_wdata_r     <= 32'h0000_0000;
            mem_num_bytes_r <= 3'd0;
            if_ack_r        <= 1'b0;
            if_err_r        <= 1'b0;
            ls_ack_r        <= 1'b0;
            ls_err_r        <= 1'b0;
            if_rdata_r      <= 32'h0000_0000;
            ls_rdata_r      <= 32'h0000_0000;
        end else begin
            if_ack_r <= 1'b0;
            if_err_r <= 1'b0;
            ls_ack_r <= 1'b0;
            ls_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_any_s) begin
                        port_ls_r       <= ls_req;
                        size_r          <= req_size_s;
                        uns_r           <= ls_req & ls_unsigned;
                        timeout_r       <= 8'd0;
                        mem_addr_r      <= req_addr_s;
                        mem_is_write_r  <= ls_req & ls_we;
                        mem_wdata_r     <= ls_req ? ls_wdata : 32'h0000_0000;
                        mem_num_bytes_r <= size_to_bytes(req_size_s);
                        mem_start_r     <= ~req_bad_s;
                        if (req_bad_s) begin
                            if (ls_req) begin
                                ls_ack_r   <= 1'b1;
                                ls_err_r   <= 1'b1;
                                ls_rdata_r <= 32'h0000_0000;
                            end else begin
                                if_ack_r   <= 1'b1;
                                if_err_r   <= 1'b1;
                                if_rdata_r <= 32'h0000_0000;
                            end
                        end
                    end else begin
                        mem_start_r <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (mem_done || timeout_hit_s) begin
                        mem_start_r <= 1'b0;
                        if (port_ls_r) begin
                            ls_ack_r   <= 1'b1;
                            ls_err_r   <= ~mem_done;
                            ls_rdata_r <= (mem_done && !mem_is_write_r) ?
                                          format_load(mem_rdata, size_r, uns_r) : 32'h0000_0000;
                        end else begin
                            if_ack_r   <= 1'b1;
                            if_err_r   <= ~mem_done;
                            if_rdata_r <= mem_done ? mem_rdata : 32'h0000_0000;
                        end
                    end else begin
                        timeout_r <= timeout_r + 8'd1;
                    end
                end
                RETIRE:  mem_start_r <= 1'b0;
                default: mem_start_r <= 1'b0;
            endcase
        end
    end

    assign if_ack        = if_ack_r;
    assign if_err        = if_err_r;
    assign if_rdata      = if_rdata_r;
    assign ls_ack        = ls_ack_r;
    assign ls_err        = ls_err_r;
    assign ls_rdata      = ls_rdata_r;
    assign mem_start     = mem_start_r;
    assign mem_addr      = mem_addr_r;
    assign mem_num_bytes = mem_num_bytes_r;
    assign mem_is_write  = mem_is_write_r;
    assign mem_wdata     = mem_wdata_r;

endmodule
